alu_issue: RTL and testbench

- Execute-issue stage directly upstream of the ALU.
- Accepts decoded instructions from decode through a valid/ready handshake and resolves operands: register-file data, sign-extended immediate, or writeback forwarding.
- Holds the result in a pipeline register that drives the ALU's left, right and op inputs, tagged with the destination register for the downstream writeback.

---
 rtl/alu_issue.sv | 162 ++++++++++++++++
 tb/tb_alu_issue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ALU issue stage: resolves operands (regfile / imm / writeback forward) into the ALU input register.
// Latency 1 cycle; held operands track writebacks. ALU_ISSUE_SKID_EN adds a skid entry.
// Backpressure: in_ready = !out_valid | out_ready (no skid), or registered !skid_valid with skid.
module alu_issue #(
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue__in_valid,
    output logic              issue__in_ready,
    input  logic [4:0]        issue__in_op,
    input  logic [REG_AW-1:0] issue__in_rd,
    input  logic [REG_AW-1:0] issue__in_rs1_idx,
    input  logic [REG_AW-1:0] issue__in_rs2_idx,
    input  logic [31:0]       issue__in_rs1_data,
    input  logic [31:0]       issue__in_rs2_data,
    input  logic [IMM_W-1:0]  issue__in_imm,
    input  logic              issue__in_use_imm,
    input  logic              issue__wb_valid,
    input  logic [REG_AW-1:0] issue__wb_rd,
    input  logic [31:0]       issue__wb_data,
    input  logic              issue__flush,
    output logic              issue__out_valid,
    input  logic              issue__out_ready,
    output logic [REG_AW-1:0] issue__out_rd,
    output logic [31:0]       alu__left,
    output logic [31:0]       alu__right,
    output logic [4:0]        alu__op
);

    typedef struct packed {
        logic [4:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_imm;
        logic [31:0]       left;
        logic [31:0]       right;
    } entry_t;

    function automatic logic wb_hit(input logic wv, input logic [REG_AW-1:0] wr,
                                    input logic [REG_AW-1:0] idx);
        return wv && (wr != '0) && (wr == idx);
    endfunction

    // A held entry picks up a writeback to any of its source registers.
    function automatic entry_t fwd_entry(input entry_t e, input logic wv,
                                         input logic [REG_AW-1:0] wr, input logic [31:0] wd);
        entry_t r;
        r = e;
        if (wb_hit(wv, wr, e.rs1))
            r.left = wd;
        if (!e.use_imm && wb_hit(wv, wr, e.rs2))
            r.right = wd;
        return r;
    endfunction

    entry_t      in_ent;
    entry_t      out_q;
    entry_t      out_fwd;
    logic        out_vld;
    logic        accept;
    logic [31:0] imm_ext;

    assign imm_ext = {{(32-IMM_W){issue__in_imm[IMM_W-1]}}, issue__in_imm};

    always_comb begin
        in_ent         = '0;
        in_ent.op      = issue__in_op;
        in_ent.rd      = issue__in_rd;
        in_ent.rs1     = issue__in_rs1_idx;
        in_ent.rs2     = issue__in_rs2_idx;
        in_ent.use_imm = issue__in_use_imm;
        if (issue__in_rs1_idx == '0)
            in_ent.left = '0;
        else if (wb_hit(issue__wb_valid, issue__wb_rd, issue__in_rs1_idx))
            in_ent.left = issue__wb_data;
        else
            in_ent.left = issue__in_rs1_data;
        if (issue__in_use_imm)
            in_ent.right = imm_ext;
        else if (issue__in_rs2_idx == '0)
            in_ent.right = '0;
        else if (wb_hit(issue__wb_valid, issue__wb_rd, issue__in_rs2_idx))
            in_ent.right = issue__wb_data;
        else
            in_ent.right = issue__in_rs2_data;
    end

    assign out_fwd = fwd_entry(out_q, issue__wb_valid, issue__wb_rd, issue__wb_data);
    assign accept  = issue__in_valid && issue__in_ready;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q;
    entry_t skid_fwd;
    logic   skid_vld;
    logic   out_free;

    assign skid_fwd        = fwd_entry(skid_q, issue__wb_valid, issue__wb_rd, issue__wb_data);
    assign out_free        = !out_vld || issue__out_ready;
    assign issue__in_ready = !skid_vld && !issue__flush;

    // in_ready is low whenever the skid is occupied, so accept and skid drain never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (issue__flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_vld  <= 1'b1;
                out_q    <= skid_fwd;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_vld <= 1'b1;
                out_q   <= in_ent;
            end else begin
                out_vld <= 1'b0;
                out_q   <= out_fwd;
            end
        end else begin
            out_q <= out_fwd;
            if (accept) begin
                skid_vld <= 1'b1;
                skid_q   <= in_ent;
            end else begin
                skid_q <= skid_fwd;
            end
        end
    end
`else
    assign issue__in_ready = (!out_vld || issue__out_ready) && !issue__flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (issue__flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld <= 1'b1;
            out_q   <= in_ent;
        end else begin
            if (issue__out_ready)
                out_vld <= 1'b0;
            out_q <= out_fwd;
        end
    end
`endif

    assign issue__out_valid = out_vld;
    assign issue__out_rd    = out_q.rd;
    assign alu__left        = out_q.left;
    assign alu__right       = out_q.right;
    assign alu__op          = out_q.op;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: scoreboard of resolved operands plus directed checks.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue__in_valid;
    logic        issue__in_ready;
    logic [4:0]  issue__in_op;
    logic [4:0]  issue__in_rd;
    logic [4:0]  issue__in_rs1_idx;
    logic [4:0]  issue__in_rs2_idx;
    logic [31:0] issue__in_rs1_data;
    logic [31:0] issue__in_rs2_data;
    logic [15:0] issue__in_imm;
    logic        issue__in_use_imm;
    logic        issue__wb_valid;
    logic [4:0]  issue__wb_rd;
    logic [31:0] issue__wb_data;
    logic        issue__flush;
    logic        issue__out_valid;
    logic        issue__out_ready;
    logic [4:0]  issue__out_rd;
    logic [31:0] alu__left;
    logic [31:0] alu__right;
    logic [4:0]  alu__op;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk                (clk),
        .rst                (rst),
        .issue__in_valid    (issue__in_valid),
        .issue__in_ready    (issue__in_ready),
        .issue__in_op       (issue__in_op),
        .issue__in_rd       (issue__in_rd),
        .issue__in_rs1_idx  (issue__in_rs1_idx),
        .issue__in_rs2_idx  (issue__in_rs2_idx),
        .issue__in_rs1_data (issue__in_rs1_data),
        .issue__in_rs2_data (issue__in_rs2_data),
        .issue__in_imm      (issue__in_imm),
        .issue__in_use_imm  (issue__in_use_imm),
        .issue__wb_valid    (issue__wb_valid),
        .issue__wb_rd       (issue__wb_rd),
        .issue__wb_data     (issue__wb_data),
        .issue__flush       (issue__flush),
        .issue__out_valid   (issue__out_valid),
        .issue__out_ready   (issue__out_ready),
        .issue__out_rd      (issue__out_rd),
        .alu__left          (alu__left),
        .alu__right         (alu__right),
        .alu__op            (alu__op)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] left;
        logic [31:0] right;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] idx);
        return issue__wb_valid && (issue__wb_rd != 5'd0) && (issue__wb_rd == idx);
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] d);
        if (idx == 5'd0) return 32'd0;
        if (hit(idx)) return issue__wb_data;
        return d;
    endfunction

    // Scoreboard: model state reflects the DUT entries for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (rst) begin
            q.delete();
        end else begin
            chk("out_valid", 32'(issue__out_valid), 32'(q.size() != 0));
`ifdef ALU_ISSUE_SKID_EN
            exp_rdy = (q.size() < 2) && !issue__flush;
`else
            exp_rdy = ((q.size() == 0) || issue__out_ready) && !issue__flush;
`endif
            chk("in_ready", 32'(issue__in_ready), 32'(exp_rdy));
            if (issue__flush) begin
                q.delete();
            end else begin
                if (issue__out_valid && issue__out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_op",    32'(alu__op),       32'(e.op));
                    chk("sb_rd",    32'(issue__out_rd), 32'(e.rd));
                    chk("sb_left",  alu__left,          e.left);
                    chk("sb_right", alu__right,         e.right);
                end
                foreach (q[i]) begin
                    if (hit(q[i].rs1)) q[i].left = issue__wb_data;
                    if (!q[i].use_imm && hit(q[i].rs2)) q[i].right = issue__wb_data;
                end
                if (issue__in_valid && issue__in_ready) begin
                    e.op      = issue__in_op;
                    e.rd      = issue__in_rd;
                    e.rs1     = issue__in_rs1_idx;
                    e.rs2     = issue__in_rs2_idx;
                    e.use_imm = issue__in_use_imm;
                    e.left    = resolve(issue__in_rs1_idx, issue__in_rs1_data);
                    e.right   = issue__in_use_imm ? {{16{issue__in_imm[15]}}, issue__in_imm}
                                                  : resolve(issue__in_rs2_idx, issue__in_rs2_data);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [15:0] imm, input logic ui);
        issue__in_valid    = 1'b1;
        issue__in_op       = op;
        issue__in_rd       = rd;
        issue__in_rs1_idx  = rs1;
        issue__in_rs2_idx  = rs2;
        issue__in_rs1_data = d1;
        issue__in_rs2_data = d2;
        issue__in_imm      = imm;
        issue__in_use_imm  = ui;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        issue__wb_valid = v;
        issue__wb_rd    = rd;
        issue__wb_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        issue__in_valid = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0);
        issue__in_valid  = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        issue__flush     = 1'b0;
        issue__out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(issue__out_valid), 32'd0);
        chk("rst_left",      alu__left,            32'd0);
        chk("rst_right",     alu__right,           32'd0);
        chk("rst_op",        32'(alu__op),         32'd0);
        chk("rst_rd",        32'(issue__out_rd),   32'd0);
        step();
        rst = 1'b0;
        issue__out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(issue__in_ready), 32'd1);

        // Immediate right operand, sign-extended
        step();
        issue__out_ready = 1'b0;
        drive(5'h0E, 5'd7, 5'd3, 5'd0, 32'h10, 32'h0, 16'hFFFF, 1'b1);
        step();
        issue__in_valid = 1'b0;
        chk("imm_valid", 32'(issue__out_valid), 32'd1);
        chk("imm_left",  alu__left,            32'h10);
        chk("imm_right", alu__right,           32'hFFFF_FFFF);
        chk("imm_op",    32'(alu__op),         32'h0E);
        issue__out_ready = 1'b1;
        step();

        // Accept-time forward, then r0 ignoring a writeback to r0 (back-to-back accept)
        drive(5'h01, 5'd5, 5'd3, 5'd0, 32'h10, 32'h0, 16'h0, 1'b0);
        wb(1'b1, 5'd3, 32'h55);
        step();
        chk("fwd_left", alu__left, 32'h55);
        drive(5'h02, 5'd6, 5'd0, 5'd0, 32'h1234, 32'h0, 16'h0, 1'b0);
        wb(1'b1, 5'd0, 32'h77);
        step();
        issue__in_valid = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        chk("r0_left", alu__left, 32'h0);
        chk("r0_op",   32'(alu__op), 32'h02);
        step();

        // Writeback while held: register right operand updates
        issue__out_ready = 1'b0;
        drive(5'h03, 5'd8, 5'd1, 5'd4, 32'h11, 32'h22, 16'h0, 1'b0);
        step();
        issue__in_valid = 1'b0;
        wb(1'b1, 5'd4, 32'hAA);
        step();
        wb(1'b0, 5'd0, 32'd0);
        chk("hold_right", alu__right,          32'hAA);
        chk("hold_left",  alu__left,           32'h11);
        chk("hold_op",    32'(alu__op),        32'h03);
        chk("hold_rd",    32'(issue__out_rd),  32'd8);
        issue__out_ready = 1'b1;
        step();

        // Writeback while held: immediate right stays, matching left updates
        issue__out_ready = 1'b0;
        drive(5'h04, 5'd9, 5'd4, 5'd4, 32'h11, 32'h22, 16'h0005, 1'b1);
        step();
        issue__in_valid = 1'b0;
        wb(1'b1, 5'd4, 32'hAA);
        step();
        wb(1'b0, 5'd0, 32'd0);
        chk("immhold_right", alu__right,   32'h5);
        chk("immhold_left",  alu__left,    32'hAA);
        chk("immhold_op",    32'(alu__op), 32'h04);
        issue__out_ready = 1'b1;
        step();

        // Flush drops the held entry and does not consume the input
        issue__out_ready = 1'b0;
        drive(5'h05, 5'd10, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0, 1'b0);
        step();
        drive(5'h06, 5'd11, 5'd1, 5'd2, 32'h3, 32'h4, 16'h0, 1'b0);
        issue__flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(issue__in_ready), 32'd0);
        step();
        issue__flush    = 1'b0;
        issue__in_valid = 1'b0;
        chk("flush_out_valid", 32'(issue__out_valid), 32'd0);
        step();
        chk("flush_no_accept", 32'(issue__out_valid), 32'd0);

`ifdef ALU_ISSUE_SKID_EN
        // Stall with A, B, C streaming; A held, B in skid, then in-order drain
        issue__out_ready = 1'b0;
        drive(5'h11, 5'd1, 5'd1, 5'd2, 32'hA1, 32'hA2, 16'h0, 1'b0);
        step();
        drive(5'h12, 5'd2, 5'd1, 5'd2, 32'hB1, 32'hB2, 16'h0, 1'b0);
        step();
        drive(5'h13, 5'd3, 5'd1, 5'd2, 32'hC1, 32'hC2, 16'h0, 1'b0);
        step();
        chk("skid_op_a",    32'(alu__op),         32'h11);
        chk("skid_in_rdy",  32'(issue__in_ready), 32'd0);
        issue__out_ready = 1'b1;
        step();
        chk("skid_op_b", 32'(alu__op), 32'h12);
        step();
        issue__in_valid = 1'b0;
        chk("skid_op_c", 32'(alu__op), 32'h13);
        step();
`endif

        // Reset while an entry is held
        issue__out_ready = 1'b0;
        drive(5'h07, 5'd12, 5'd1, 5'd2, 32'h5, 32'h6, 16'h0, 1'b0);
        step();
        issue__in_valid = 1'b0;
        chk("mid_valid", 32'(issue__out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(issue__out_valid), 32'd0);
        chk("mid_rst_left",  alu__left,             32'd0);
        chk("mid_rst_op",    32'(alu__op),          32'd0);
        chk("mid_rst_rd",    32'(issue__out_rd),    32'd0);
        step();
        rst = 1'b0;
        issue__out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", 32'(issue__in_ready), 32'd1);
        step();

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            issue__in_valid    = 1'($urandom_range(0, 1));
            issue__in_op       = 5'($urandom_range(0, 31));
            issue__in_rd       = 5'($urandom_range(0, 31));
            issue__in_rs1_idx  = 5'($urandom_range(0, 7));
            issue__in_rs2_idx  = 5'($urandom_range(0, 7));
            issue__in_rs1_data = $urandom;
            issue__in_rs2_data = $urandom;
            issue__in_imm      = 16'($urandom);
            issue__in_use_imm  = 1'($urandom_range(0, 1));
            wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            issue__out_ready   = ($urandom_range(0, 3) != 0);
            issue__flush       = ($urandom_range(0, 24) == 0);
            step();
        end

        issue__in_valid  = 1'b0;
        issue__flush     = 1'b0;
        issue__out_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        repeat (4) step();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
